up_down_cnt_monitor: RTL and testbench

Passive checker that sits on the output bus of the 4-bit up/down counter and decodes its behaviour. It samples the count every clock and infers the counting direction. It also reports wrap-around events and direction reversals, and flags any step that is not +1, -1 or hold. It is the read side of the counter's count interface, used in-system for health monitoring and in benches as a self-checking observer.

---
 rtl/up_down_cnt_monitor.sv | 112 +++++++++++
 tb/tb_up_down_cnt_monitor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/up_down_cnt_monitor.sv
// up_down_cnt_monitor: passive observer for an up/down counter's output bus.
// Infers the counting direction from consecutive samples. Reports wraps,
// direction reversals and illegal steps, and keeps wrap and error tallies.
module up_down_cnt_monitor #(
    parameter int WIDTH = 4
) (
    input  logic             cnt_clk,
    input  logic             cnt_rst,
    input  logic             mon_en,
    input  logic [WIDTH-1:0] count_in,
    output logic             dir_out,
    output logic             dir_valid,
    output logic             dir_chg,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             step_err,
    output logic [7:0]       wrap_total,
    output logic [7:0]       err_cnt,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        TRACK = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] delta;
    logic             step_up;
    logic             step_dn;
    logic             step_hold;

    assign state_out = state;

    // Classify the step between the previous and the current sample (mod 2^WIDTH)
    always_comb begin
        delta     = count_in - prev_q;
        step_up   = (delta == ONE);
        step_dn   = (delta == '1);
        step_hold = (delta == '0);
    end

    // Monitor FSM with registered direction, pulse and tally outputs
    always_ff @(posedge cnt_clk or negedge cnt_rst) begin
        if (!cnt_rst) begin
            state      <= IDLE;
            prev_q     <= '0;
            dir_out    <= 1'b0;
            dir_valid  <= 1'b0;
            dir_chg    <= 1'b0;
            wrap_up    <= 1'b0;
            wrap_dn    <= 1'b0;
            step_err   <= 1'b0;
            wrap_total <= '0;
            err_cnt    <= '0;
        end else begin
            dir_chg  <= 1'b0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
            step_err <= 1'b0;
            if (!mon_en) begin
                state     <= IDLE;
                dir_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= SYNC;
                        dir_valid <= 1'b0;
                    end
                    SYNC: begin
                        prev_q    <= count_in;
                        dir_valid <= 1'b0;
                        state     <= TRACK;
                    end
                    TRACK: begin
                        prev_q <= count_in;
                        if (step_up) begin
                            dir_out   <= 1'b1;
                            dir_valid <= 1'b1;
                            if (dir_valid && !dir_out) dir_chg <= 1'b1;
                            if (prev_q == '1) begin
                                wrap_up    <= 1'b1;
                                wrap_total <= wrap_total + 8'd1;
                            end
                        end else if (step_dn) begin
                            dir_out   <= 1'b0;
                            dir_valid <= 1'b1;
                            if (dir_valid && dir_out) dir_chg <= 1'b1;
                            if (prev_q == '0) begin
                                wrap_dn    <= 1'b1;
                                wrap_total <= wrap_total + 8'd1;
                            end
                        end else if (!step_hold) begin
                            step_err  <= 1'b1;
                            dir_valid <= 1'b0;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        dir_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_up_down_cnt_monitor.sv
// Directed, table-driven bench for up_down_cnt_monitor (WIDTH = 4).
module tb_up_down_cnt_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] cnt;
    logic       dir_out, dir_valid, dir_chg, wrap_up, wrap_dn, step_err;
    logic [7:0] wrap_total, err_cnt;
    logic [1:0] state_out;

    up_down_cnt_monitor #(.WIDTH(4)) dut (
        .cnt_clk   (clk),
        .cnt_rst   (rst_n),
        .mon_en    (en),
        .count_in  (cnt),
        .dir_out   (dir_out),
        .dir_valid (dir_valid),
        .dir_chg   (dir_chg),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .step_err  (step_err),
        .wrap_total(wrap_total),
        .err_cnt   (err_cnt),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] c;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];
    int unsigned applied    = 0;
    int unsigned miscompares = 0;

    // Output image: {state, dir, valid, chg, wrap_up, wrap_dn, err, wrap_total, err_cnt}
    function automatic logic [23:0] pk(input logic [1:0] st, input logic d, input logic v,
                                       input logic chg, input logic wu, input logic wd,
                                       input logic er, input logic [7:0] wt, input logic [7:0] ec);
        return {st, d, v, chg, wu, wd, er, wt, ec};
    endfunction

    task automatic add(input logic e, input logic [3:0] c, input logic [1:0] st, input logic d,
                       input logic v, input logic chg, input logic wu, input logic wd,
                       input logic er, input logic [7:0] wt, input logic [7:0] ec);
        vec_t x;
        x.en  = e;
        x.c   = c;
        x.exp = pk(st, d, v, chg, wu, wd, er, wt, ec);
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic [23:0] exp);
        logic [23:0] act;
        act = {state_out, dir_out, dir_valid, dir_chg, wrap_up, wrap_dn, step_err, wrap_total, err_cnt};
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h (st,d,v,chg,wu,wd,err | wrap_total | err_cnt)",
                     name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] c);
        @(negedge clk);
        en  = e;
        cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sync with steady count, then up-ramp with a 5-cycle hold at 9
        add(1, 0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 2'd2, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 9; i++) add(1, 4'(i), 2'd2, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)  add(1, 9, 2'd2, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 10; i <= 15; i++) add(1, 4'(i), 2'd2, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0,  2'd2, 1, 1, 0, 1, 0, 0, 1, 0);   // 15 -> 0 wrap_up
        add(1, 1,  2'd2, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 2,  2'd2, 1, 1, 0, 0, 0, 0, 1, 0);
        add(1, 3,  2'd2, 1, 1, 0, 0, 0, 0, 1, 0);
        // Down run 3,2,1,0,15,14
        add(1, 2,  2'd2, 0, 1, 1, 0, 0, 0, 1, 0);   // reversal
        add(1, 1,  2'd2, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0,  2'd2, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 15, 2'd2, 0, 1, 0, 0, 1, 0, 2, 0);   // 0 -> 15 wrap_dn
        add(1, 14, 2'd2, 0, 1, 0, 0, 0, 0, 2, 0);
        // Illegal jump, then 4,5,6,5,4 reversal pattern
        add(1, 4,  2'd2, 0, 0, 0, 0, 0, 1, 2, 1);
        add(1, 5,  2'd2, 1, 1, 0, 0, 0, 0, 2, 1);   // first valid step: no chg
        add(1, 6,  2'd2, 1, 1, 0, 0, 0, 0, 2, 1);
        add(1, 5,  2'd2, 0, 1, 1, 0, 0, 0, 2, 1);
        add(1, 4,  2'd2, 0, 1, 0, 0, 0, 0, 2, 1);
        add(1, 5,  2'd2, 1, 1, 1, 0, 0, 0, 2, 1);
        add(1, 6,  2'd2, 1, 1, 0, 0, 0, 0, 2, 1);
        add(1, 7,  2'd2, 1, 1, 0, 0, 0, 0, 2, 1);
        add(1, 12, 2'd2, 1, 0, 0, 0, 0, 1, 2, 2);   // 7 -> 12 illegal
        add(1, 13, 2'd2, 1, 1, 0, 0, 0, 0, 2, 2);   // recovers without chg
        // Drop enable: IDLE, valid cleared, counters retained
        add(0, 13, 2'd0, 1, 0, 0, 0, 0, 0, 2, 2);
        add(0, 13, 2'd0, 1, 0, 0, 0, 0, 0, 2, 2);

        rst_n = 1'b0;
        en    = 1'b0;
        cnt   = '0;
        #12;
        check("reset_state", pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].c);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // err_cnt saturation: 300 illegal jumps alternating 0 <-> 8
        drive(1, 0);
        drive(1, 0);
        check("resync_track", pk(2'd2, 1, 0, 0, 0, 0, 0, 2, 2));
        for (int i = 0; i < 300; i++) begin
            drive(1, (i % 2 == 0) ? 4'd8 : 4'd0);
            if (i == 251) check("err_cnt_254", pk(2'd2, 1, 0, 0, 0, 0, 1, 2, 254));
        end
        check("err_cnt_sat", pk(2'd2, 1, 0, 0, 0, 0, 1, 2, 255));

        // Asynchronous reset in mid-TRACK
        drive(1, 1);
        check("pre_reset", pk(2'd2, 1, 1, 0, 0, 0, 0, 2, 255));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("reset_held", pk(2'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        cnt   = 4'd5;
        @(posedge clk);
        #1;
        check("post_rst_sync", pk(2'd1, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 5);
        check("post_rst_track", pk(2'd2, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 6);
        check("post_rst_step", pk(2'd2, 1, 1, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
